// File: rtl/fir_delay_line_decim_if.sv
// Sample-stream bundle between a sample source, the FIR delay line and the filter.
// master = source side (drives the strobe/sample), slave = delay line.
interface fir_delay_line_decim_if #(
   parameter int I_WIDTH = 16,
   parameter int ORDER   = 17
);
   // i_en is a fire-and-forget strobe: i_data is taken on every rising edge where i_en=1,
   // there is no back-pressure. o_en is a one-cycle strobe meaning o_data is a fresh,
   // fully primed, decimation-aligned tap set that the filter captures at the end of that cycle.
   logic                       i_en;
   logic [I_WIDTH-1:0]         i_data;
   logic [I_WIDTH*ORDER-1:0]   o_data;
   logic                       o_en;
   logic                       o_primed;

   modport master (
      output i_en,
      output i_data,
      input  o_data,
      input  o_en,
      input  o_primed
   );

   modport slave (
      input  i_en,
      input  i_data,
      output o_data,
      output o_en,
      output o_primed
   );
endinterface

// File: rtl/fir_delay_line_decim.sv
// ORDER-deep tap line feeding a multiplierless FIR, with a decimated, priming-gated
// filter enable issued once every DECIM accepted samples.
module fir_delay_line_decim #(
   parameter int I_WIDTH = 16,
   parameter int ORDER   = 17,
   parameter int DECIM   = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   fir_delay_line_decim_if.slave fir
);
   localparam int FW = $clog2(ORDER + 1);
   // A one-bit phase register is kept for DECIM=1; it never leaves 0 since PHASE_LAST is 0.
   localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam logic [FW-1:0] FILL_MAX   = FW'(ORDER);
   localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM - 1);

   logic [ORDER-1:0][I_WIDTH-1:0] taps;
   logic [FW-1:0]                 fill;
   logic [FW-1:0]                 fill_next;
   logic [PW-1:0]                 phase;
   logic                          en_q;
   logic                          primed_q;

   always_comb begin
      fill_next = fill;
      if (fill != FILL_MAX) fill_next = fill + FW'(1);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         taps     <= '0;
         fill     <= '0;
         phase    <= '0;
         en_q     <= 1'b0;
         primed_q <= 1'b0;
      end else begin
         en_q <= 1'b0;
         if (fir.i_en) begin
            taps[0] <= fir.i_data;
            for (int k = 1; k < ORDER; k++) taps[k] <= taps[k-1];
            fill     <= fill_next;
            primed_q <= (fill_next == FILL_MAX);
            phase    <= (phase == PHASE_LAST) ? '0 : phase + PW'(1);
            // The wrap accept that also completes the fill still fires.
            en_q     <= (phase == PHASE_LAST) && (fill_next == FILL_MAX);
         end
      end
   end

   assign fir.o_data   = taps;
   assign fir.o_en     = en_q;
   assign fir.o_primed = primed_q;
endmodule

// File: tb/tb_fir_delay_line_decim.sv
// Directed bench: a DECIM=4 and a DECIM=1 delay line share one stimulus stream and are
// checked against hand-computed values and a tap-history queue.
module tb_fir_delay_line_decim;
   localparam int IW = 16;
   localparam int OR = 17;
   localparam int CW = IW * OR;

   logic i_clk;
   logic i_rst;
   int   n_assert;
   int   n_fail;
   int   en_cnt_a;
   int   en_cnt_g;
   logic [IW-1:0] exp_q[$];
   logic [CW-1:0] snap_a;
   logic [CW-1:0] snap_g;
   logic [CW-1:0] hold;

   fir_delay_line_decim_if #(.I_WIDTH(IW), .ORDER(OR)) bus4 ();
   fir_delay_line_decim_if #(.I_WIDTH(IW), .ORDER(OR)) bus1 ();

   fir_delay_line_decim #(.I_WIDTH(IW), .ORDER(OR), .DECIM(4)) dut4 (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .fir   (bus4)
   );

   fir_delay_line_decim #(.I_WIDTH(IW), .ORDER(OR), .DECIM(1)) dut1 (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .fir   (bus1)
   );

   // clock / reset
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   function automatic logic [CW-1:0] exp_data();
      logic [CW-1:0] r;
      r = '0;
      for (int k = 0; k < OR; k++)
         if (k < exp_q.size()) r[k*IW +: IW] = exp_q[k];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // driver: one clock of stimulus, returns at the following falling edge
   task automatic drive(input logic rst, input logic en, input logic [IW-1:0] d);
      i_rst       = rst;
      bus4.i_en   = en;
      bus4.i_data = d;
      bus1.i_en   = en;
      bus1.i_data = d;
      @(posedge i_clk);
      if (rst) exp_q.delete();
      else if (en) begin
         exp_q.push_front(d);
         if (exp_q.size() > OR) void'(exp_q.pop_back());
      end
      @(negedge i_clk);
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      en_cnt_a = 0;
      en_cnt_g = 0;
      snap_a   = '0;
      snap_g   = '0;
      i_rst    = 1'b1;
      bus4.i_en = 1'b0; bus4.i_data = '0;
      bus1.i_en = 1'b0; bus1.i_data = '0;
      @(negedge i_clk);

      // reset state, with a strobe that reset must drop
      drive(1'b1, 1'b0, 16'h0);
      drive(1'b1, 1'b1, 16'h1234);
      chk("rst o_data", bus4.o_data, '0);
      chk("rst o_en", CW'(bus4.o_en), '0);
      chk("rst o_primed", CW'(bus4.o_primed), '0);

      // accepts 1..40 back-to-back
      for (int k = 1; k <= 40; k++) begin
         drive(1'b0, 1'b1, IW'(k));
         chk($sformatf("A d4 o_en k=%0d", k), CW'(bus4.o_en), CW'(k >= 20 && k % 4 == 0));
         chk($sformatf("A d4 primed k=%0d", k), CW'(bus4.o_primed), CW'(k >= 17));
         chk($sformatf("A d4 o_data k=%0d", k), bus4.o_data, exp_data());
         chk($sformatf("A d1 o_en k=%0d", k), CW'(bus1.o_en), CW'(k >= 17));
         chk($sformatf("A d1 tap0 k=%0d", k), CW'(bus1.o_data[IW-1:0]), CW'(k));
         if (k <= 20 && bus4.o_en) begin
            en_cnt_a++;
            snap_a = bus4.o_data;
         end
         if (k == 20) begin
            chk("A tap0 @20", CW'(bus4.o_data[15:0]), CW'(20));
            chk("A tap1 @20", CW'(bus4.o_data[31:16]), CW'(19));
            chk("A tap16 @20", CW'(bus4.o_data[271:256]), CW'(4));
         end
         if (k == 40) begin
            chk("A tap0 @40", CW'(bus4.o_data[15:0]), CW'(40));
            chk("A tap16 @40", CW'(bus4.o_data[271:256]), CW'(24));
         end
      end

      // same 1..20, strobed one cycle in five
      drive(1'b1, 1'b0, 16'h0);
      for (int k = 1; k <= 20; k++) begin
         drive(1'b0, 1'b1, IW'(k));
         chk($sformatf("G o_en k=%0d", k), CW'(bus4.o_en), CW'(k == 20));
         if (bus4.o_en) begin
            en_cnt_g++;
            snap_g = bus4.o_data;
         end
         hold = bus4.o_data;
         for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 16'hDEAD);
            chk($sformatf("G idle hold k=%0d i=%0d", k, i), bus4.o_data, hold);
            chk($sformatf("G idle o_en k=%0d i=%0d", k, i), CW'(bus4.o_en), '0);
         end
      end
      chk("G o_en count", CW'(en_cnt_g), CW'(en_cnt_a));
      chk("G o_en count abs", CW'(en_cnt_g), CW'(1));
      chk("G o_data at o_en", snap_g, snap_a);

      // reset collides with accept 10
      drive(1'b1, 1'b0, 16'h0);
      for (int k = 1; k <= 9; k++) drive(1'b0, 1'b1, IW'(k));
      drive(1'b1, 1'b1, IW'(10));
      chk("R o_data", bus4.o_data, '0);
      chk("R o_primed", CW'(bus4.o_primed), '0);
      chk("R o_en", CW'(bus4.o_en), '0);
      for (int j = 1; j <= 20; j++) begin
         drive(1'b0, 1'b1, IW'(100 + j));
         chk($sformatf("R o_en j=%0d", j), CW'(bus4.o_en), CW'(j == 20));
         chk($sformatf("R o_data j=%0d", j), bus4.o_data, exp_data());
         if (j == 1) chk("R dropped absent", CW'(bus4.o_data[31:16]), '0);
         if (j == 20) chk("R tap16 @20", CW'(bus4.o_data[271:256]), CW'(104));
      end

      // signed extremes, bit-exact in every tap
      drive(1'b1, 1'b0, 16'h0);
      for (int k = 0; k < 18; k++) begin
         drive(1'b0, 1'b1, (k % 3 == 0) ? 16'h8000 : (k % 3 == 1) ? 16'h7FFF : 16'hFFFF);
         chk($sformatf("S o_data k=%0d", k), bus4.o_data, exp_data());
         if (k == 2) begin
            chk("S tap0", CW'(bus4.o_data[15:0]), CW'(16'hFFFF));
            chk("S tap1", CW'(bus4.o_data[31:16]), CW'(16'h7FFF));
            chk("S tap2", CW'(bus4.o_data[47:32]), CW'(16'h8000));
            chk("S tap3", CW'(bus4.o_data[63:48]), CW'(0));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
